// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types for the clock-gating controller: FSM state encoding and a
// small elaboration-time helper.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        IDLE = 2'd1,
        OFF  = 2'd2,
        WAKE = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Bundle of the client handshake and gating-cell signals around clk_gate_ctrl,
// so integrators and benches can pass them around as one object.
interface clk_gate_ctrl_if;
    logic req;
    logic busy;
    logic sleep_en;
    logic test_en;
    logic en;
    logic ack;
    logic gated;

    // master: the client/power manager side driving requests
    modport master (
        output req, busy, sleep_en, test_en,
        input  en, ack, gated
    );

    modport slave (
        input  req, busy, sleep_en, test_en,
        output en, ack, gated
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-timeout clock gating controller: drops the enable to an external gating
// cell after IdleCycles of inactivity and re-grants after WakeCycles of settle.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic busy_i,
    input  logic sleep_en_i,
    input  logic test_en_i,
    output logic en_o,
    output logic ack_o,
    output logic gated_o
);

    localparam int CntW = $clog2(max_int(IdleCycles, WakeCycles) + 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles);
    localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic            w_active;

    // req and busy are treated identically; either one counts as activity
    assign w_active = req_i | busy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_active) begin
                        r_state <= IDLE;
                        r_cnt   <= CntOne;
                    end
                end
                IDLE: begin
                    if (w_active) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == IdleLast) begin
                        // timeout reached: gate only when allowed, else park here
                        if (sleep_en_i) begin
                            r_state <= OFF;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                OFF: begin
                    if (w_active) begin
                        r_state <= WAKE;
                        r_cnt   <= CntOne;
                    end
                end
                WAKE: begin
                    // settle runs to completion regardless of inputs
                    if (r_cnt == WakeLast) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // test_en_i bypasses the FSM so DFT can force the clock on immediately
    assign en_o    = (r_state != OFF) | test_en_i;
    assign ack_o   = (r_state == RUN) & req_i;
    assign gated_o = (r_state == OFF);

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl (IdleCycles=4, WakeCycles=2): directed
// gate/wake/abort/inhibit/DFT/reset scenarios followed by random traffic.
module tb_clk_gate_ctrl;

    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;

    logic clk_i = 1'b0;
    logic rst_ni;

    clk_gate_ctrl_if gif ();

    clk_gate_ctrl #(
        .IdleCycles (IDLE_N),
        .WakeCycles (WAKE_N)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (gif.req),
        .busy_i     (gif.busy),
        .sleep_en_i (gif.sleep_en),
        .test_en_i  (gif.test_en),
        .en_o       (gif.en),
        .ack_o      (gif.ack),
        .gated_o    (gif.gated)
    );

    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_fail;

    // Reference model: length of the current quiet streak, remaining settle
    // cycles, and whether the clock is gated.
    int m_quiet;
    int m_wake_left;
    bit m_gated;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_quiet     = 0;
        m_wake_left = 0;
        m_gated     = 1'b0;
    endtask

    // Apply inputs just after a rising edge and compare all outputs mid-cycle.
    task automatic drive(input bit req, input bit busy, input bit sleep, input bit test);
        logic exp_en, exp_ack, exp_gated;
        gif.req      = req;
        gif.busy     = busy;
        gif.sleep_en = sleep;
        gif.test_en  = test;
        @(negedge clk_i);
        exp_gated = m_gated;
        exp_en    = !m_gated || test;
        exp_ack   = req && !m_gated && (m_wake_left == 0) && (m_quiet == 0);
        check("en", gif.en, exp_en);
        check("ack", gif.ack, exp_ack);
        check("gated", gif.gated, exp_gated);
    endtask

    task automatic tick();
        bit act;
        @(posedge clk_i);
        act = gif.req || gif.busy;
        if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_gated) begin
            if (act) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_N;
            end
        end else if (act) begin
            m_quiet = 0;
        end else if (m_quiet < IDLE_N) begin
            m_quiet++;
        end else if (gif.sleep_en) begin
            m_gated = 1'b1;
            m_quiet = 0;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        gif.req = 1'b1; gif.busy = 1'b0; gif.sleep_en = 1'b1; gif.test_en = 1'b0;
        rst_ni = 1'b0;
        #2;
        check("rst_en", gif.en, 1'b1);
        check("rst_ack", gif.ack, 1'b1);
        check("rst_gated", gif.gated, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        repeat (3) begin drive(1, 0, 1, 0); tick(); end

        // gate: quiet from k=0, enable drops at k=IDLE_N+1
        for (int k = 0; k <= 5; k++) begin
            drive(0, 0, 1, 0);
            check("gate_en", gif.en, k < 5);
            check("gate_gated", gif.gated, k == 5);
            tick();
        end
        drive(0, 0, 1, 0); tick();

        drive(0, 0, 1, 1);
        check("dft_en", gif.en, 1'b1);
        check("dft_gated", gif.gated, 1'b1);
        check("dft_ack", gif.ack, 1'b0);
        tick();

        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            check("sleep_drop_gated", gif.gated, 1'b1);
            tick();
        end

        // wake: request in OFF, ack after WAKE_N settle cycles
        for (int k = 0; k <= 3; k++) begin
            drive(1, 0, 1, 0);
            check("wake_en", gif.en, k > 0);
            check("wake_ack", gif.ack, k == 3);
            tick();
        end

        // idle abort: busy pulse at k=3 restarts the quiet count
        for (int k = 0; k <= 9; k++) begin
            drive(0, k == 3, 1, 0);
            check("abort_gated", gif.gated, k == 9);
            tick();
        end

        // request drop during settle still completes the wake
        drive(1, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 0);
        check("wake_drop_en", gif.en, 1'b1);
        tick();

        // sleep inhibit holds the clock on indefinitely
        for (int k = 0; k <= 50; k++) begin
            drive(0, 0, 0, 0);
            check("inhibit_en", gif.en, 1'b1);
            check("inhibit_gated", gif.gated, 1'b0);
            tick();
        end
        drive(0, 0, 1, 0);
        check("inhibit_rise_gated", gif.gated, 1'b0);
        tick();
        drive(0, 0, 1, 0);
        check("inhibit_off_gated", gif.gated, 1'b1);
        tick();

        // asynchronous reset during WAKE
        drive(1, 0, 1, 0); tick();
        rst_ni = 1'b0;
        #1;
        check("rst_wake_en", gif.en, 1'b1);
        check("rst_wake_gated", gif.gated, 1'b0);
        check("rst_wake_ack", gif.ack, 1'b1);
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drive(1, 0, 1, 0);
        check("post_rst_ack", gif.ack, 1'b1);
        tick();

        // random traffic with sparse activity so gating actually happens
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 9) == 0, ($urandom % 11) == 0,
                  ($urandom % 4) != 0, ($urandom % 10) == 0);
            if (($urandom % 97) == 0) begin
                rst_ni = 1'b0;
                #1;
                check("rand_rst_en", gif.en, 1'b1);
                check("rand_rst_gated", gif.gated, 1'b0);
                model_reset();
                #1 rst_ni = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IdleCycles, default 16: consecutive idle cycles (>=1) required before the clock is gated.
REQ-002 The block SHALL have parameter WakeCycles, default 4: settle cycles (>=1) after ungating before ack_o is allowed.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single ungated source clock for all state.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_i, input, 1 bit: client requests a running gated clock.
REQ-006 The block SHALL have port busy_i, input, 1 bit: gated domain reports work in flight.
REQ-007 The block SHALL have port sleep_en_i, input, 1 bit: 1 permits gating; 0 keeps the clock running.
REQ-008 The block SHALL have port test_en_i, input, 1 bit: DFT override forcing the clock on.
REQ-009 The block SHALL have port en_o, output, 1 bit: enable to the BUFGCE-based gating cell.
REQ-010 The block SHALL have port ack_o, output, 1 bit: gated clock is stable and the request is granted.
REQ-011 The block SHALL have port gated_o, output, 1 bit: status, clock currently gated by the FSM.

Function
REQ-012 The FSM SHALL have states RUN, IDLE, OFF, WAKE and a counter cnt of width $clog2(max(IdleCycles,WakeCycles)+1).
REQ-013 In RUN, if req_i=0 and busy_i=0, the FSM SHALL go to IDLE with cnt<=1; otherwise it SHALL stay in RUN.
REQ-014 In IDLE, if req_i or busy_i is set, the FSM SHALL return to RUN next cycle and idle counting SHALL restart on re-entry.
REQ-015 In IDLE with neither set, if cnt==IdleCycles and sleep_en_i=1, the FSM SHALL go to OFF.
REQ-016 In IDLE with neither set, if cnt==IdleCycles and sleep_en_i=0, the FSM SHALL stay in IDLE with cnt held.
REQ-017 In IDLE with neither set and cnt<IdleCycles, cnt SHALL increment.
REQ-018 Gating latency: if req_i=busy_i=0 from cycle t onward with sleep_en_i=1, en_o SHALL first read 0 at cycle t+IdleCycles+1.
REQ-019 In OFF, req_i or busy_i SHALL move the FSM to WAKE with cnt<=1.
REQ-020 In WAKE, at cnt==WakeCycles the FSM SHALL go to RUN; otherwise cnt SHALL increment.
REQ-021 Inputs SHALL not abort WAKE; a req_i drop during WAKE SHALL still complete WAKE, then follow RUN rules.
REQ-022 en_o SHALL equal (state!=OFF) OR test_en_i, with no register stage on the test_en_i path.
REQ-023 ack_o SHALL equal (state==RUN) AND req_i, combinationally; it SHALL be 0 in IDLE, OFF and WAKE.
REQ-024 gated_o SHALL equal (state==OFF), independent of test_en_i.
REQ-025 test_en_i SHALL not alter FSM state or cnt.
REQ-026 sleep_en_i falling while in OFF SHALL not wake the clock; only req_i or busy_i wakes it.
REQ-027 If req_i and busy_i change in the same cycle, the FSM SHALL evaluate their OR; no priority SHALL exist between them.

Reset
REQ-028 While rst_ni=0, state SHALL be RUN and cnt 0, giving en_o=1, ack_o=req_i and gated_o=0.
REQ-029 Reset asserted mid-IDLE, OFF or WAKE SHALL return to RUN asynchronously, and en_o SHALL rise without waiting for a clock edge.
REQ-030 Reset release SHALL be synchronous to clk_i at integration; the block SHALL add no synchronizer.

Structure
REQ-031 Package clk_gate_ctrl_pkg SHALL hold the state enum typedef (RUN, IDLE, OFF, WAKE).
REQ-032 The block SHALL be a single module with no sub-modules; the gating cell is instantiated by the integrator, not here.
REQ-033 State and cnt SHALL be the only flops; all outputs SHALL be combinational from state and inputs.

Verification (IdleCycles=4, WakeCycles=2)
REQ-034 Gate: req_i falls at cycle 10, busy_i=0, sleep_en_i=1 -> en_o=1 through cycle 14, en_o=0 and gated_o=1 at cycle 15.
REQ-035 Wake: req_i rises at cycle 20 in OFF -> en_o=1 at cycle 21, ack_o=0 at cycles 21-22, ack_o=1 at cycle 23.
REQ-036 Idle abort: req_i low at cycles 10-12, busy_i pulses at cycle 13 -> never OFF; a new idle run from cycle 14 gates at cycle 19.
REQ-037 Sleep inhibit: sleep_en_i=0 with idle inputs for 50 cycles -> en_o stays 1 and gated_o=0; sleep_en_i rising at cycle 60 -> OFF at cycle 61.
REQ-038 DFT: test_en_i=1 while in OFF -> en_o=1 in the same cycle, gated_o stays 1, ack_o=0.
REQ-039 Reset mid-WAKE: rst_ni low at cnt=1 -> RUN immediately and en_o=1; after release with req_i=1, ack_o=1 with no wake delay.
